vfu_mask_steer: RTL and testbench

- Per-lane steering unit between the mask unit broadcast (mask_i / mask_valid_i / mask_ready_o) and the two lane functional units, valu and vmfpu.
- Today the broadcast is accepted by whichever unit raises ready, which breaks when masked ALU and MFPU instructions are in flight concurrently.
- The lane sequencer registers each masked instruction with its target FU and its mask beat count, in issue order. The block routes every mask beat to exactly one FU, strictly in that order.

---
 rtl/vfu_mask_steer.sv | 137 +++++++++++++
 tb/tb_vfu_mask_steer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vfu_mask_steer.sv
// Per-lane mask steering: routes each mask-unit beat to valu or vmfpu in the
// issue order recorded by the lane sequencer (FIFO of {fu, beats}).
module vfu_mask_steer #(
   parameter int unsigned NrLanes      = 0,
   parameter int unsigned Depth        = 4,
   parameter int unsigned BeatCntWidth = 16,
   parameter int unsigned StrbWidth    = 8
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    flush_i,
   input  logic                    reg_valid_i,
   output logic                    reg_ready_o,
   input  logic                    reg_fu_i,
   input  logic [BeatCntWidth-1:0] reg_beats_i,
   input  logic [StrbWidth-1:0]    mask_i,
   input  logic                    mask_valid_i,
   output logic                    mask_ready_o,
   output logic [StrbWidth-1:0]    alu_mask_o,
   output logic                    alu_mask_valid_o,
   input  logic                    alu_mask_ready_i,
   output logic [StrbWidth-1:0]    mfpu_mask_o,
   output logic                    mfpu_mask_valid_o,
   input  logic                    mfpu_mask_ready_i,
   output logic                    insn_done_o,
   output logic                    busy_o
);

   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned CntW = PtrW + 1;

   logic                    fu_q    [Depth];
   logic [BeatCntWidth-1:0] beats_q [Depth];

   logic [PtrW-1:0]         rptr_q, rptr_d;
   logic [PtrW-1:0]         wptr_q, wptr_d;
   logic [CntW-1:0]         cnt_q, cnt_d;
   logic [BeatCntWidth-1:0] beat_q, beat_d;

   logic                    empty_s;
   logic                    full_s;
   logic                    head_fu_s;
   logic [BeatCntWidth-1:0] head_beats_s;
   logic                    route_en_s;
   logic                    zero_head_s;
   logic                    hs_s;
   logic                    last_beat_s;
   logic                    push_s;
   logic                    pop_s;

   assign empty_s      = (cnt_q == {CntW{1'b0}});
   assign full_s       = (cnt_q == CntW'(Depth));
   assign head_fu_s    = fu_q[rptr_q];
   assign head_beats_s = beats_q[rptr_q];

   // Flush blanks every handshake in its cycle so nothing is consumed or retired.
   assign route_en_s  = !empty_s && !flush_i && (head_beats_s != {BeatCntWidth{1'b0}});
   assign zero_head_s = !empty_s && !flush_i && (head_beats_s == {BeatCntWidth{1'b0}});
   assign last_beat_s = ((beat_q + {{(BeatCntWidth-1){1'b0}}, 1'b1}) == head_beats_s);

   // Valids are derived from mask_valid_i only, never from FU ready.
   assign alu_mask_valid_o  = route_en_s && !head_fu_s && mask_valid_i;
   assign mfpu_mask_valid_o = route_en_s &&  head_fu_s && mask_valid_i;
   assign alu_mask_o        = mask_i;
   assign mfpu_mask_o       = mask_i;

   assign mask_ready_o = route_en_s && (head_fu_s ? mfpu_mask_ready_i : alu_mask_ready_i);
   assign hs_s         = mask_valid_i && mask_ready_o;
   assign pop_s        = zero_head_s || (hs_s && last_beat_s);
   assign insn_done_o  = pop_s;

   assign reg_ready_o = !full_s && !flush_i;
   assign push_s      = reg_valid_i && reg_ready_o;
   assign busy_o      = !empty_s;

   // Next-state for pointers, occupancy and the head beat counter.
   always_comb begin
      rptr_d = rptr_q;
      wptr_d = wptr_q;
      cnt_d  = cnt_q;
      beat_d = beat_q;
      if (flush_i) begin
         rptr_d = {PtrW{1'b0}};
         wptr_d = {PtrW{1'b0}};
         cnt_d  = {CntW{1'b0}};
         beat_d = {BeatCntWidth{1'b0}};
      end else begin
         if (push_s) begin
            wptr_d = wptr_q + {{(PtrW-1){1'b0}}, 1'b1};
         end else begin
            wptr_d = wptr_q;
         end
         if (pop_s) begin
            rptr_d = rptr_q + {{(PtrW-1){1'b0}}, 1'b1};
            beat_d = {BeatCntWidth{1'b0}};
         end else if (hs_s) begin
            beat_d = beat_q + {{(BeatCntWidth-1){1'b0}}, 1'b1};
         end else begin
            beat_d = beat_q;
         end
         case ({push_s, pop_s})
            2'b10:   cnt_d = cnt_q + {{(CntW-1){1'b0}}, 1'b1};
            2'b01:   cnt_d = cnt_q - {{(CntW-1){1'b0}}, 1'b1};
            default: cnt_d = cnt_q;
         endcase
      end
   end

   // Control state registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rptr_q <= {PtrW{1'b0}};
         wptr_q <= {PtrW{1'b0}};
         cnt_q  <= {CntW{1'b0}};
         beat_q <= {BeatCntWidth{1'b0}};
      end else begin
         rptr_q <= rptr_d;
         wptr_q <= wptr_d;
         cnt_q  <= cnt_d;
         beat_q <= beat_d;
      end
   end

   // Entry storage, written at the tail on an accepted registration.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < Depth; i++) begin
            fu_q[i]    <= 1'b0;
            beats_q[i] <= {BeatCntWidth{1'b0}};
         end
      end else if (push_s) begin
         fu_q[wptr_q]    <= reg_fu_i;
         beats_q[wptr_q] <= reg_beats_i;
      end
   end

endmodule

// File: tb/tb_vfu_mask_steer.sv
// Directed bench for vfu_mask_steer: routing order, stalls, wrap, zero-beat
// entries, flush and asynchronous reset.
module tb_vfu_mask_steer;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        reg_valid;
   logic        reg_ready;
   logic        reg_fu;
   logic [15:0] reg_beats;
   logic [7:0]  mask;
   logic        mask_valid;
   logic        mask_ready;
   logic [7:0]  alu_mask;
   logic        alu_valid;
   logic        alu_ready;
   logic [7:0]  mfpu_mask;
   logic        mfpu_valid;
   logic        mfpu_ready;
   logic        insn_done;
   logic        busy;

   int n_chk = 0;
   int n_err = 0;

   logic       log_fu   [64];
   logic [7:0] log_data [64];
   int         log_n  = 0;
   int         done_n = 0;
   int         both_n = 0;

   vfu_mask_steer #(.NrLanes(0), .Depth(4), .BeatCntWidth(16), .StrbWidth(8)) dut (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
      .reg_valid_i(reg_valid), .reg_ready_o(reg_ready), .reg_fu_i(reg_fu), .reg_beats_i(reg_beats),
      .mask_i(mask), .mask_valid_i(mask_valid), .mask_ready_o(mask_ready),
      .alu_mask_o(alu_mask), .alu_mask_valid_o(alu_valid), .alu_mask_ready_i(alu_ready),
      .mfpu_mask_o(mfpu_mask), .mfpu_mask_valid_o(mfpu_valid), .mfpu_mask_ready_i(mfpu_ready),
      .insn_done_o(insn_done), .busy_o(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Record every FU handshake and retirement pulse.
   always @(posedge clk) begin
      if (rst_n) begin
         if (alu_valid && alu_ready && mfpu_valid && mfpu_ready) both_n <= both_n + 1;
         if (alu_valid && alu_ready) begin
            log_fu[log_n[5:0]]   <= 1'b0;
            log_data[log_n[5:0]] <= alu_mask;
            log_n <= log_n + 1;
         end else if (mfpu_valid && mfpu_ready) begin
            log_fu[log_n[5:0]]   <= 1'b1;
            log_data[log_n[5:0]] <= mfpu_mask;
            log_n <= log_n + 1;
         end
         if (insn_done) done_n <= done_n + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic regi(input logic fu, input logic [15:0] beats);
      reg_valid = 1'b1;
      reg_fu    = fu;
      reg_beats = beats;
      tick();
      reg_valid = 1'b0;
   endtask

   int  base, dbase;
   logic sent;
   logic [0:4] exp_fu;

   initial begin
      rst_n = 1'b0; flush = 1'b0; reg_valid = 1'b0; reg_fu = 1'b0; reg_beats = 16'd0;
      mask = 8'h00; mask_valid = 1'b0; alu_ready = 1'b0; mfpu_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      tick();

      // Empty after reset: beats stall.
      mask_valid = 1'b1; mask = 8'hAA; alu_ready = 1'b1; mfpu_ready = 1'b1;
      #1;
      chk("rst_mask_ready", mask_ready, 0);
      chk("rst_alu_valid", alu_valid, 0);
      chk("rst_mfpu_valid", mfpu_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_reg_ready", reg_ready, 1);
      chk("rst_done", insn_done, 0);
      tick();
      mask_valid = 1'b0;

      // Single ALU instruction of 3 beats.
      regi(1'b0, 16'd3);
      mask_valid = 1'b1; alu_ready = 1'b1; mfpu_ready = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         mask = 8'(k);
         #1;
         chk("t2_alu_valid", alu_valid, 1);
         chk("t2_mfpu_valid", mfpu_valid, 0);
         chk("t2_alu_data", alu_mask, k);
         chk("t2_mfpu_data", mfpu_mask, k);
         chk("t2_done", insn_done, (k == 3) ? 1 : 0);
         chk("t2_busy", busy, 1);
         tick();
      end
      mask_valid = 1'b0;
      #1 chk("t2_busy_fall", busy, 0);

      // Interleaved ALU/MFPU with ready stalls.
      regi(1'b0, 16'd2);
      regi(1'b1, 16'd2);
      regi(1'b0, 16'd1);
      base = log_n; dbase = done_n;
      exp_fu = 5'b00110;
      mask_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         mask = 8'h10 + 8'(k);
         sent = 1'b0;
         for (int t = 0; t < 20 && !sent; t++) begin
            alu_ready  = ((k + t) % 3) != 0;
            mfpu_ready = ((k + t) % 2) == 1;
            #1;
            sent = mask_ready;
            tick();
         end
         chk("t3_beat_sent", sent, 1);
      end
      mask_valid = 1'b0; alu_ready = 1'b1; mfpu_ready = 1'b1;
      #1;
      chk("t3_count", log_n - base, 5);
      chk("t3_done_count", done_n - dbase, 3);
      chk("t3_both", both_n, 0);
      for (int k = 0; k < 5; k++) begin
         chk("t3_fu", log_fu[base + k], exp_fu[k]);
         chk("t3_data", log_data[base + k], 8'h10 + 8'(k));
      end
      chk("t3_busy", busy, 0);

      // Fill to Depth, then push into the freed slot with wrap.
      regi(1'b0, 16'd1);
      regi(1'b1, 16'd1);
      regi(1'b0, 16'd1);
      regi(1'b1, 16'd1);
      chk("t4_full", reg_ready, 0);
      chk("t4_wptr0", dut.wptr_q, 0);
      reg_valid = 1'b1; reg_fu = 1'b0; reg_beats = 16'd1;
      mask_valid = 1'b1; mask = 8'h21;
      #1;
      chk("t4_full_pop", reg_ready, 0);
      chk("t4_b1_alu", alu_valid, 1);
      chk("t4_b1_done", insn_done, 1);
      tick();
      mask = 8'h22;
      #1;
      chk("t4_ready_after_pop", reg_ready, 1);
      chk("t4_b2_mfpu", mfpu_valid, 1);
      chk("t4_b2_alu", alu_valid, 0);
      tick();
      reg_valid = 1'b0; mask = 8'h23;
      #1;
      chk("t4_wptr_wrap", dut.wptr_q, 1);
      chk("t4_b3_alu", alu_valid, 1);
      tick();
      mask = 8'h24;
      #1 chk("t4_b4_mfpu", mfpu_valid, 1);
      tick();
      mask = 8'h25;
      #1;
      chk("t4_b5_alu", alu_valid, 1);
      chk("t4_b5_done", insn_done, 1);
      tick();
      #1;
      chk("t4_empty_ready", mask_ready, 0);
      chk("t4_empty_busy", busy, 0);
      mask_valid = 1'b0;

      // Zero-beat MFPU entry retires without a handshake.
      regi(1'b1, 16'd0);
      reg_valid = 1'b1; reg_fu = 1'b0; reg_beats = 16'd1;
      mask_valid = 1'b1; mask = 8'h31;
      #1;
      chk("t5_zero_done", insn_done, 1);
      chk("t5_zero_ready", mask_ready, 0);
      chk("t5_zero_mfpu", mfpu_valid, 0);
      tick();
      reg_valid = 1'b0;
      #1;
      chk("t5_alu_valid", alu_valid, 1);
      chk("t5_alu_done", insn_done, 1);
      tick();
      mask_valid = 1'b0;
      #1 chk("t5_busy", busy, 0);

      // Flush mid-instruction.
      regi(1'b1, 16'd4);
      mask_valid = 1'b1;
      mask = 8'h41; tick();
      mask = 8'h42; tick();
      mask_valid = 1'b0; flush = 1'b1;
      #1 chk("t6_flush_done", insn_done, 0);
      tick();
      flush = 1'b0;
      #1;
      chk("t6_busy", busy, 0);
      chk("t6_beat_q", dut.beat_q, 0);
      chk("t6_reg_ready", reg_ready, 1);
      regi(1'b0, 16'd1);
      mask_valid = 1'b1; mask = 8'h43;
      #1;
      chk("t6_alu_valid", alu_valid, 1);
      chk("t6_mfpu_valid", mfpu_valid, 0);
      chk("t6_done", insn_done, 1);
      tick();

      // Asynchronous reset mid-stream.
      mask_valid = 1'b0;
      regi(1'b0, 16'd3);
      mask_valid = 1'b1; mask = 8'h51;
      #1 chk("t7_pre_valid", alu_valid, 1);
      #1 rst_n = 1'b0;
      #1;
      chk("t7_mask_ready", mask_ready, 0);
      chk("t7_alu_valid", alu_valid, 0);
      chk("t7_mfpu_valid", mfpu_valid, 0);
      chk("t7_busy", busy, 0);
      chk("t7_done", insn_done, 0);
      chk("t7_reg_ready", reg_ready, 1);
      mask_valid = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
